reset_sync_pipeline: RTL and testbench
======================================

RESET_SYNC_PIPELINE -- requirements
Module: reset_sync_pipeline

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data path width in bits (1..64).
REQ-002 The block SHALL have parameter STAGES, default 3, meaning pipeline register stages (1..8).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning reset synchroniser flop count (2..4).
REQ-004 The block SHALL have parameter ADD, default 1, meaning constant added to each beat (WIDTH bits).
REQ-005 The block SHALL have port clk  input  1  the clock; all logic SHALL be clocked on its rising edge.
REQ-006 The block SHALL have port async_rst_n  input  1  reset: asynchronous, active-low.
REQ-007 The block SHALL have port sync_rst  input  1  synchronous flush, active-high.
REQ-008 The block SHALL have port in_data  input  WIDTH  upstream beat payload.
REQ-009 The block SHALL have port in_valid  input  1  upstream beat present.
REQ-010 The block SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-011 The block SHALL have port out_data  output  WIDTH  downstream beat payload.
REQ-012 The block SHALL have port out_valid  output  1  downstream beat present.
REQ-013 The block SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-014 The block SHALL have port rst_done  output  1  high when the pipeline is out of reset and accepting.

Function
REQ-015 Internal reset: rst_sync_n = last flop of a SYNC_STAGES chain loaded with 1, cleared asynchronously by async_rst_n; reset_active = !rst_sync_n | sync_rst.
REQ-016 Transfer in SHALL occur when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-017 Each stage k SHALL hold valid_k/data_k; stage k SHALL load from stage k-1 (stage 0 from input) when its slot is empty or its content leaves in the same cycle.
REQ-018 in_ready SHALL be !valid_0 | (stage 0 advances this cycle), combinational from out_ready, and SHALL be 0 while reset_active.
REQ-019 ADD SHALL be applied once, at stage 0: data_0 = (in_data + ADD) mod 2^WIDTH, carry discarded.
REQ-020 With out_ready held 1, latency SHALL be exactly STAGES cycles and throughput one beat per cycle.
REQ-021 With out_ready = 0, out_data/out_valid SHALL hold; the pipeline SHALL absorb up to STAGES beats, then deassert in_ready.
REQ-022 Beats SHALL never be dropped, duplicated or reordered outside reset.
REQ-023 sync_rst asserted SHALL clear all valid_k on the next edge regardless of handshakes; in-flight beats are discarded; sync_rst has priority over simultaneous in/out transfers.
REQ-024 rst_done SHALL be a register equal to !reset_active delayed one cycle.

Reset
REQ-025 On async_rst_n = 0 the synchroniser SHALL clear asynchronously; rst_sync_n rises SYNC_STAGES edges after async_rst_n deasserts.
REQ-026 Pipeline registers SHALL be reset synchronously by reset_active only: valid_k = 0, data_k = 0.
REQ-027 Output reset values: out_valid = 0, out_data = 0, in_ready = 0, rst_done = 0.
REQ-028 async_rst_n assertion mid-transfer SHALL discard all in-flight beats within one clk edge of rst_sync_n falling.

Configuration
REQ-029 Macro RESET_SYNC_PIPELINE_BEAT_CNT_EN defined: the block SHALL add output beat_count [31:0], incremented on each output transfer, wrapping 0xFFFFFFFF -> 0, cleared by reset_active.
REQ-030 Macro RESET_SYNC_PIPELINE_BEAT_CNT_EN undefined: port beat_count and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset release: async_rst_n low 5 cycles then high, SYNC_STAGES=2 -> in_ready 0 for 2 edges after release, rst_done rises 1 edge later.
REQ-032 Streaming: defaults, out_ready=1, in_data 0x0000..0x0009 consecutive -> out_data 0x0001..0x000A, each 3 cycles after acceptance.
REQ-033 Backpressure: out_ready=0, 5 beats offered -> 3 accepted, in_ready=0; out_ready=1 -> 3 beats out in order, no loss.
REQ-034 Wrap: in_data 0xFFFF, ADD=1 -> out_data 0x0000.
REQ-035 Flush: sync_rst 1 cycle with 3 beats in flight and in_valid=1 -> out_valid 0 next edge, no flushed beat ever appears, rst_done low 1 cycle.
REQ-036 Counter (macro defined): 7 output transfers -> beat_count = 7; sync_rst -> beat_count = 0.

Source files
------------

// File: rtl/reset_sync_pipeline.sv
// Elastic STAGES-deep pipeline that adds ADD at stage 0, with an internal reset synchroniser and a synchronous flush.
// Define RESET_SYNC_PIPELINE_BEAT_CNT_EN to add the 32-bit output beat counter port beat_count.
module reset_sync_pipeline #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [63:0] ADD         = 64'd1
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             sync_rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             rst_done
`ifdef RESET_SYNC_PIPELINE_BEAT_CNT_EN
  ,
  output logic [31:0]      beat_count
`endif
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync_n;
  logic                   reset_active;
  logic [STAGES-1:0]      valid_q;
  logic [STAGES-1:0]      valid_d;
  logic [STAGES-1:0]      load_s;
  logic [WIDTH-1:0]       data_q [STAGES];
  logic [WIDTH-1:0]       data_d [STAGES];
  logic                   rst_done_q;
  logic [WIDTH-1:0]       add_s;

  assign add_s = ADD[WIDTH-1:0];

  // Reset synchroniser: clears asynchronously, releases after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n   = sync_q[SYNC_STAGES-1];
  assign reset_active = ~rst_sync_n | sync_rst;

  // A stage loads when it is empty or its content moves on this cycle.
  always_comb begin
    load_s             = '0;
    load_s[STAGES-1]   = ~valid_q[STAGES-1] | out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      load_s[k] = ~valid_q[k] | load_s[k+1];
    end
  end

  assign in_ready = load_s[0] & ~reset_active;

  // Next-state for valid/data of every stage; reset_active wins over handshakes.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (reset_active) begin
      valid_d = '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        data_d[k] = '0;
      end
    end else begin
      if (load_s[0]) begin
        valid_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data + add_s;
        end else begin
          data_d[0] = data_q[0];
        end
      end else begin
        valid_d[0] = valid_q[0];
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (load_s[k]) begin
          valid_d[k] = valid_q[k-1];
          data_d[k]  = data_q[k-1];
        end else begin
          valid_d[k] = valid_q[k];
        end
      end
    end
  end

  // Pipeline registers are cleared only through reset_active (synchronously).
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  // rst_done follows !reset_active one cycle late.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= ~reset_active;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign rst_done  = rst_done_q;

`ifdef RESET_SYNC_PIPELINE_BEAT_CNT_EN
  logic [31:0] beat_count_q;
  logic [31:0] beat_count_d;

  // Output-transfer counter; wraps naturally at 32 bits.
  always_comb begin
    beat_count_d = beat_count_q;
    if (reset_active) begin
      beat_count_d = 32'd0;
    end else if (out_valid && out_ready) begin
      beat_count_d = beat_count_q + 32'd1;
    end else begin
      beat_count_d = beat_count_q;
    end
  end

  always_ff @(posedge clk) begin
    beat_count_q <= beat_count_d;
  end

  assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_reset_sync_pipeline.sv
// Scoreboard bench for reset_sync_pipeline (defaults: WIDTH 16, STAGES 3, SYNC_STAGES 2, ADD 1).
module tb_reset_sync_pipeline;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        sync_rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        rst_done;
`ifdef RESET_SYNC_PIPELINE_BEAT_CNT_EN
  logic [31:0] beat_count;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          accepted    = 0;
  bit          chk_lat     = 1'b0;
  logic [15:0] exp_q [$];
  int          stamp_q [$];

  always #5 clk = ~clk;

  reset_sync_pipeline #(
    .WIDTH(16), .STAGES(3), .SYNC_STAGES(2), .ADD(64'd1)
  ) dut (
    .clk(clk),
    .async_rst_n(async_rst_n),
    .sync_rst(sync_rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rst_done(rst_done)
`ifdef RESET_SYNC_PIPELINE_BEAT_CNT_EN
    ,
    .beat_count(beat_count)
`endif
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes just before the edge, then return at the next negedge.
  task automatic cycle();
    logic [15:0] d;
    int          st;
    #1;
    if (!async_rst_n || sync_rst) begin
      exp_q.delete();
      stamp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("spurious_beat", {63'd0, out_valid}, 64'd0);
        end else begin
          d  = exp_q.pop_front();
          st = stamp_q.pop_front();
          chk_eq("out_data", {48'd0, out_data}, {48'd0, d});
          if (chk_lat) chk_eq("latency", 64'(cyc - st), 64'(S));
        end
      end
      if (in_valid && in_ready) begin
        d = in_data + 16'd1;
        exp_q.push_back(d);
        stamp_q.push_back(cyc);
        accepted++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    async_rst_n = 1'b0;
    sync_rst    = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'h0000;
    out_ready   = 1'b1;
    @(negedge clk);

    // Reset and release
    repeat (5) cycle();
    chk_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("rst_out_data", {48'd0, out_data}, 64'd0);
    chk_eq("rst_rst_done", {63'd0, rst_done}, 64'd0);
    async_rst_n = 1'b1;
    cycle();
    chk_eq("rel1_in_ready", {63'd0, in_ready}, 64'd0);
    chk_eq("rel1_rst_done", {63'd0, rst_done}, 64'd0);
    cycle();
    chk_eq("rel2_in_ready", {63'd0, in_ready}, 64'd1);
    chk_eq("rel2_rst_done", {63'd0, rst_done}, 64'd0);
    cycle();
    chk_eq("rel3_rst_done", {63'd0, rst_done}, 64'd1);

    // Streaming at full rate
    chk_lat  = 1'b1;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (S + 2) cycle();
    chk_lat = 1'b0;
    chk_eq("stream_accepted", 64'(accepted), 64'd10);
    chk_eq("stream_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: only STAGES beats fit
    out_ready = 1'b0;
    accepted  = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'h0100 + 16'(accepted);
      cycle();
    end
    chk_eq("bp_accepted", 64'(accepted), 64'd3);
    chk_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
    cycle();
    chk_eq("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    chk_eq("bp_hold_data", {48'd0, out_data}, 64'h0101);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (S + 2) cycle();
    chk_eq("bp_drained", 64'(exp_q.size()), 64'd0);

    // Carry wraps
    chk_lat  = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk_eq("wrap_valid", {63'd0, out_valid}, 64'd1);
    chk_eq("wrap_data", {48'd0, out_data}, 64'h0000);
    repeat (2) cycle();
    chk_lat = 1'b0;

    // Flush with three beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'h0200 + 16'(i);
      cycle();
    end
    in_data  = 16'h0300;
    sync_rst = 1'b1;
    cycle();
    sync_rst = 1'b0;
    in_valid = 1'b0;
    chk_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("flush_rst_done", {63'd0, rst_done}, 64'd0);
    cycle();
    chk_eq("flush_rst_done_back", {63'd0, rst_done}, 64'd1);
    out_ready = 1'b1;
    repeat (S + 2) cycle();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0400 + 16'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (S + 2) cycle();
    chk_eq("flush_drained", 64'(exp_q.size()), 64'd0);

    // Async reset in the middle of traffic
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0500;
    cycle();
    cycle();
    in_valid    = 1'b0;
    async_rst_n = 1'b0;
    cycle();
    chk_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("arst_in_ready", {63'd0, in_ready}, 64'd0);
    async_rst_n = 1'b1;
    out_ready   = 1'b1;
    repeat (S + 3) cycle();
    chk_eq("arst_rst_done", {63'd0, rst_done}, 64'd1);

`ifdef RESET_SYNC_PIPELINE_BEAT_CNT_EN
    sync_rst = 1'b1;
    cycle();
    sync_rst = 1'b0;
    chk_eq("cnt_cleared", {32'd0, beat_count}, 64'd0);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0600 + 16'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (S + 2) cycle();
    chk_eq("cnt_seven", {32'd0, beat_count}, 64'd7);
    sync_rst = 1'b1;
    cycle();
    sync_rst = 1'b0;
    chk_eq("cnt_flush", {32'd0, beat_count}, 64'd0);
`endif

    chk_eq("final_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
